// File: rtl/rgb_stream_source.sv
// AXI4-Stream RGB raster generator: background patterns plus a square spot overlay.
// Beats are fully registered; frame settings are captured at each start of frame.
module rgb_stream_source #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int SPOT_SIZE = 4,
  parameter int LINE_GAP  = 0,
  parameter int FRAME_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  bg_mode,
  input  logic        spot_en,
  input  logic [10:0] spot_x,
  input  logic [10:0] spot_y,
  input  logic [23:0] spot_color,
  output logic [23:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

  localparam logic [10:0] X_LAST   = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST   = 11'(HEIGHT - 1);
  localparam logic [15:0] LGAP_M1  = (LINE_GAP > 0) ? 16'(LINE_GAP - 1) : 16'd0;
  localparam logic [15:0] FGAP_M1  = (FRAME_GAP > 0) ? 16'(FRAME_GAP - 1) : 16'd0;
  localparam logic [11:0] SPOT_W   = 12'(SPOT_SIZE);
  localparam logic [13:0] WIDTH_14 = 14'(WIDTH);

  state_t      state_q;
  logic [10:0] x_q, y_q;
  logic [1:0]  mode_q;
  logic        spot_en_q;
  logic [10:0] spot_x_q, spot_y_q;
  logic [23:0] spot_color_q;
  logic [15:0] gap_cnt_q;
  logic        frame_gap_q;

  logic [10:0] x_adv_d, y_adv_d;
  logic [23:0] pix_adv_d, pix_start_d;
  logic        accept_d, line_end_d, frame_end_d, end_dec_d, start_d, stop_d;

  // 12-bit compares let the spot clip at the right/bottom edge instead of wrapping.
  function automatic logic [23:0] pixel(input logic [10:0] px, input logic [10:0] py,
                                        input logic [1:0] mode, input logic sen,
                                        input logic [10:0] sx, input logic [10:0] sy,
                                        input logic [23:0] scol);
    logic [11:0] px12, py12, sx12, sy12;
    logic [2:0]  bar;
    logic [23:0] bg;
    px12 = {1'b0, px};
    py12 = {1'b0, py};
    sx12 = {1'b0, sx};
    sy12 = {1'b0, sy};
    bar  = 3'({px, 3'b000} / WIDTH_14);
    case (mode)
      2'd0: bg = 24'h000000;
      2'd1: bg = {px[7:0], py[7:0], 8'h00};
      2'd2: bg = {px[7:0], px[7:0], px[7:0]};
      default: begin
        case (bar)
          3'd0: bg = 24'hFFFFFF;
          3'd1: bg = 24'hFFFF00;
          3'd2: bg = 24'h00FFFF;
          3'd3: bg = 24'h00FF00;
          3'd4: bg = 24'hFF00FF;
          3'd5: bg = 24'hFF0000;
          3'd6: bg = 24'h0000FF;
          default: bg = 24'h000000;
        endcase
      end
    endcase
    if (sen && (px12 >= sx12) && (px12 < sx12 + SPOT_W) &&
        (py12 >= sy12) && (py12 < sy12 + SPOT_W))
      return scol;
    return bg;
  endfunction

  always_comb begin
    x_adv_d = x_q + 11'd1;
    y_adv_d = y_q;
    if (x_q == X_LAST) begin
      x_adv_d = '0;
      y_adv_d = y_q + 11'd1;
    end
    pix_adv_d   = pixel(x_adv_d, y_adv_d, mode_q, spot_en_q, spot_x_q, spot_y_q, spot_color_q);
    pix_start_d = pixel(11'd0, 11'd0, bg_mode, spot_en, spot_x, spot_y, spot_color);
    accept_d    = (state_q == S_ACTIVE) && m_tvalid && m_tready;
    line_end_d  = accept_d && (x_q == X_LAST);
    frame_end_d = line_end_d && (y_q == Y_LAST);
    // Frame-boundary decision: after the frame gap, or straight away when there is none.
    end_dec_d   = (frame_end_d && (FRAME_GAP == 0)) ||
                  ((state_q == S_GAP) && frame_gap_q && (gap_cnt_q == 16'd0));
    start_d     = enable && ((state_q == S_IDLE) || end_dec_d);
    stop_d      = !enable && end_dec_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      mode_q       <= '0;
      spot_en_q    <= 1'b0;
      spot_x_q     <= '0;
      spot_y_q     <= '0;
      spot_color_q <= '0;
      gap_cnt_q    <= '0;
      frame_gap_q  <= 1'b0;
      m_tdata      <= '0;
      m_tvalid     <= 1'b0;
      m_tuser      <= 1'b0;
      m_tlast      <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      busy         <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state_q)
        S_ACTIVE: begin
          if (frame_end_d) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            m_tvalid    <= 1'b0;
            state_q     <= S_GAP;
            frame_gap_q <= 1'b1;
            gap_cnt_q   <= FGAP_M1;
          end else if (accept_d) begin
            x_q     <= x_adv_d;
            y_q     <= y_adv_d;
            m_tdata <= pix_adv_d;
            m_tuser <= 1'b0;
            m_tlast <= (x_adv_d == X_LAST);
            if (line_end_d && (LINE_GAP > 0)) begin
              // Next beat is staged now and only released when the gap expires.
              m_tvalid    <= 1'b0;
              state_q     <= S_GAP;
              frame_gap_q <= 1'b0;
              gap_cnt_q   <= LGAP_M1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q != 16'd0) begin
            gap_cnt_q <= gap_cnt_q - 16'd1;
          end else if (!frame_gap_q) begin
            m_tvalid <= 1'b1;
            state_q  <= S_ACTIVE;
          end
        end
        default: ;
      endcase
      if (start_d) begin
        mode_q       <= bg_mode;
        spot_en_q    <= spot_en;
        spot_x_q     <= spot_x;
        spot_y_q     <= spot_y;
        spot_color_q <= spot_color;
        x_q          <= '0;
        y_q          <= '0;
        m_tdata      <= pix_start_d;
        m_tuser      <= 1'b1;
        m_tlast      <= 1'b0;
        m_tvalid     <= 1'b1;
        busy         <= 1'b1;
        state_q      <= S_ACTIVE;
      end else if (stop_d) begin
        m_tvalid <= 1'b0;
        busy     <= 1'b0;
        state_q  <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_rgb_stream_source.sv
// Scoreboard bench for rgb_stream_source on an 8x4 raster; a second instance
// with a line gap is watched only for idle-cycle spacing.
module tb_rgb_stream_source;

  localparam int W = 8;
  localparam int H = 4;
  localparam int FG = 2;

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, spot_en, tready;
  logic [1:0]  bg_mode;
  logic [10:0] spot_x, spot_y;
  logic [23:0] spot_color;

  logic [23:0] tdata [2];
  logic [15:0] fcount [2];
  logic [1:0]  tvalid, tuser, tlast, fdone, busy;

  rgb_stream_source #(.WIDTH(W), .HEIGHT(H), .SPOT_SIZE(4), .LINE_GAP(0), .FRAME_GAP(FG)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .bg_mode(bg_mode), .spot_en(spot_en),
    .spot_x(spot_x), .spot_y(spot_y), .spot_color(spot_color),
    .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tready(tready), .m_tuser(tuser[0]),
    .m_tlast(tlast[0]), .frame_done(fdone[0]), .frame_count(fcount[0]), .busy(busy[0]));

  rgb_stream_source #(.WIDTH(W), .HEIGHT(H), .SPOT_SIZE(4), .LINE_GAP(3), .FRAME_GAP(FG)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .bg_mode(bg_mode), .spot_en(spot_en),
    .spot_x(spot_x), .spot_y(spot_y), .spot_color(spot_color),
    .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tready(tready), .m_tuser(tuser[1]),
    .m_tlast(tlast[1]), .frame_done(fdone[1]), .frame_count(fcount[1]), .busy(busy[1]));

  int    tests = 0;
  int    fails = 0;
  int    acc_cnt = 0;
  int    exp_fc = 0;
  bit    mon_en = 1'b0;
  beat_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 1 gradient, 2 gray ramp, 3 colour bars; spot = 4x4 green spot at (6,3)
  task automatic push_frame(input int kind, input bit spot);
    logic [23:0] bars [8];
    beat_t b;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        case (kind)
          1: b.d = {8'(x), 8'(y), 8'h00};
          2: b.d = {8'(x), 8'(x), 8'(x)};
          default: b.d = bars[x];
        endcase
        if (spot && x >= 6 && y >= 3) b.d = 24'h00FF00;
        b.u   = (x == 0 && y == 0);
        b.l   = (x == W - 1);
        b.eof = (x == W - 1 && y == H - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check($sformatf("wait_acc_%0d", target), 32'(acc_cnt >= target), 32'd1);
  endtask

  // Scoreboard monitor for dut0
  bit          prev_stall = 1'b0;
  bit          done_pend = 1'b0;
  logic [25:0] prev_beat;
  beat_t       got_b;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_stall = 1'b0;
      done_pend  = 1'b0;
    end else begin
      check("frame_done", 32'(fdone[0]), 32'(done_pend));
      if (done_pend) check("frame_count", 32'(fcount[0]), 32'(exp_fc[15:0]));
      done_pend = 1'b0;
      if (prev_stall) begin
        check("hold_valid", 32'(tvalid[0]), 32'd1);
        check("hold_beat", 32'({tdata[0], tuser[0], tlast[0]}), 32'(prev_beat));
      end
      prev_stall = tvalid[0] && !tready;
      prev_beat  = {tdata[0], tuser[0], tlast[0]};
      if (tvalid[0] && tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got tdata 0x%0h with no beat expected at %0t", tdata[0], $time);
        end else begin
          got_b = exp_q.pop_front();
          check($sformatf("beat%0d_data", acc_cnt), 32'(tdata[0]), 32'(got_b.d));
          check($sformatf("beat%0d_user_last", acc_cnt), 32'({tuser[0], tlast[0]}), 32'({got_b.u, got_b.l}));
          if (got_b.eof) begin
            done_pend = 1'b1;
            exp_fc++;
          end
        end
        acc_cnt++;
      end
    end
  end

  // Idle-gap checker for both instances: tvalid-low cycles after each accepted tlast
  bit meas [2];
  int gcnt [2];
  int gexp [2];
  int line [2];
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!mon_en || !busy[i]) begin
        meas[i] = 1'b0;
        line[i] = 0;
      end else begin
        if (meas[i]) begin
          if (!tvalid[i]) gcnt[i]++;
          else begin
            check($sformatf("gap_dut%0d", i), 32'(gcnt[i]), 32'(gexp[i]));
            meas[i] = 1'b0;
          end
        end
        if (tvalid[i] && tready && tlast[i]) begin
          meas[i] = 1'b1;
          gcnt[i] = 0;
          gexp[i] = (line[i] == H - 1) ? FG : ((i == 0) ? 0 : 3);
          line[i] = (line[i] == H - 1) ? 0 : line[i] + 1;
        end
      end
    end
  end

  int base;
  int n;
  initial begin
    rst = 1'b1; enable = 1'b0; tready = 1'b1; bg_mode = 2'd2; spot_en = 1'b0;
    spot_x = 11'd6; spot_y = 11'd3; spot_color = 24'h00FF00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 32'(tvalid[0]), 32'd0);
    check("rst_tdata", 32'(tdata[0]), 32'd0);
    check("rst_tuser_tlast", 32'({tuser[0], tlast[0]}), 32'd0);
    check("rst_done_busy", 32'({fdone[0], busy[0]}), 32'd0);
    check("rst_frame_count", 32'(fcount[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1'b1;

    // Frames 1-4: gray, gray+spot, gray under random tready, gray+spot with enable dropped
    push_frame(2, 1'b0);
    push_frame(2, 1'b1);
    push_frame(2, 1'b0);
    push_frame(2, 1'b1);
    enable = 1'b1;
    wait_acc(5);
    spot_en = 1'b1;
    wait_acc(37);
    spot_en = 1'b0;
    wait_acc(64);
    n = 0;
    while (acc_cnt < 96 && n < 2000) begin
      @(posedge clk); #1;
      tready = 1'($urandom_range(0, 1));
      if (acc_cnt >= 70) spot_en = 1'b1;
      n++;
    end
    check("random_phase_done", 32'(acc_cnt >= 96), 32'd1);
    tready = 1'b1;
    wait_acc(106);
    check("busy_mid_frame", 32'(busy[0]), 32'd1);
    enable = 1'b0;
    wait_acc(108);
    spot_x = 11'd2;
    wait_acc(128);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("idle_busy", 32'(busy[0]), 32'd0);
    check("idle_tvalid", 32'(tvalid[0]), 32'd0);
    check("idle_frame_count", 32'(fcount[0]), 32'd4);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("idle_still_low", 32'(tvalid[0]), 32'd0);
    check("queue_drained_1", 32'(exp_q.size()), 32'd0);

    // Reset while a beat is stalled mid-line
    @(posedge clk); #1;
    spot_x = 11'd6; spot_en = 1'b0; bg_mode = 2'd2;
    push_frame(2, 1'b0);
    enable = 1'b1;
    wait_acc(133);
    tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_tvalid", 32'(tvalid[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b0; enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_tvalid", 32'(tvalid[0]), 32'd0);
    check("post_rst_frame_count", 32'(fcount[0]), 32'd0);
    check("post_rst_busy_tuser", 32'({busy[0], tuser[0], tlast[0]}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_fc = 0;
    tready = 1'b1;
    mon_en = 1'b1;

    // Colour bars then gradient, enable dropped during the second frame
    bg_mode = 2'd3;
    base = acc_cnt;
    push_frame(3, 1'b0);
    push_frame(1, 1'b0);
    enable = 1'b1;
    wait_acc(base + 5);
    bg_mode = 2'd1;
    wait_acc(base + 40);
    enable = 1'b0;
    wait_acc(base + 64);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("final_frame_count", 32'(fcount[0]), 32'd2);
    check("final_busy", 32'(busy[0]), 32'd0);
    check("queue_drained_2", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rgb_stream_source.md
Name: rgb_stream_source

Overview:
AXI4-Stream video transmitter. It generates 24-bit RGB raster frames with a background pattern and a square "laser spot" overlay. It drives the slave input of the colour/laser detection IP in simulation and on-board bring-up. Output is registered and fully honours downstream backpressure. Frames carry SOF (tuser) and EOL (tlast) markers.

Parameters:
WIDTH, 640, active pixels per line (2..2047)
HEIGHT, 480, active lines per frame (1..2047)
SPOT_SIZE, 4, spot edge length in pixels (1..64)
LINE_GAP, 0, idle cycles (tvalid low) inserted after each accepted tlast
FRAME_GAP, 16, idle cycles inserted after the last beat of a frame (replaces LINE_GAP for that line)

Ports:
clk  in  1  clock
rst  in  1  reset
enable  in  1  level; start frames while high
bg_mode  in  2  0 black, 1 gradient, 2 gray ramp, 3 colour bars
spot_en  in  1  enable spot overlay
spot_x  in  11  spot left column
spot_y  in  11  spot top line
spot_color  in  24  spot pixel value
m_tdata  out  24  pixel {R[23:16],G[15:8],B[7:0]}
m_tvalid  out  1  beat valid
m_tready  in  1  downstream ready
m_tuser  out  1  start of frame, pixel (0,0) only
m_tlast  out  1  last pixel of each line
frame_done  out  1  one-cycle pulse when the final beat of a frame is accepted
frame_count  out  16  completed frames, wraps 0xFFFF->0
busy  out  1  high from frame start until the end of the frame gap

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk. Outputs on reset: m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, frame_done=0, frame_count=0, busy=0. State returns to IDLE and x=y=0. Reset mid-frame aborts immediately; no tlast is emitted.
- FSM states: IDLE, ACTIVE, GAP.
  - IDLE: if enable is sampled high at edge N, latch bg_mode, spot_en, spot_x, spot_y and spot_color into shadow registers. Go to ACTIVE with pixel (0,0) presented at edge N (tvalid=1, tuser=1 visible in cycle N+1). busy=1.
  - ACTIVE: a beat is accepted when tvalid&&tready. On acceptance, advance x; at x=WIDTH-1 set x=0 and advance y. The next beat is registered at the same edge, so back-to-back transfers run at 1 beat/clk.
    - Accepting the last beat of a line: if LINE_GAP=0, continue ACTIVE; otherwise go to GAP.
    - Accepting the last beat of the frame (x=WIDTH-1, y=HEIGHT-1): pulse frame_done and increment frame_count. Go to GAP for FRAME_GAP cycles; if FRAME_GAP=0, go directly to the end-of-gap decision.
  - GAP: tvalid=0 while a counter runs. When it expires:
    - after a line gap, present the next line;
    - after a frame gap, go to ACTIVE (new frame, shadow registers relatched) if enable=1, else go to IDLE with busy=0.
- enable is sampled only at frame boundaries. Deasserting it mid-frame completes the current frame. Spot and mode inputs likewise take effect only at the next SOF.
- AXIS rules:
  - tvalid never depends combinationally on tready.
  - Once tvalid=1, tdata/tuser/tlast hold stable until accepted.
  - tready low stalls indefinitely with no loss or duplication.
- Pixel value for (x,y):
  - If spot_en and spot_x<=x<spot_x+SPOT_SIZE and spot_y<=y<spot_y+SPOT_SIZE, output spot_color. Compare in 12 bits so the spot clips at the right and bottom edges with no wrap to column/line 0.
  - Otherwise output the background:
    - mode0: 0x000000
    - mode1: {x[7:0], y[7:0], 8'h00}
    - mode2: {x[7:0], x[7:0], x[7:0]}
    - mode3: eight equal bars indexed by x*8/WIDTH. Order: white, yellow, cyan, green, magenta, red, blue, black (0xFFFFFF, 0xFFFF00, 0x00FFFF, 0x00FF00, 0xFF00FF, 0xFF0000, 0x0000FF, 0x000000).
- tuser=1 only for (0,0); tlast=1 only for x=WIDTH-1. Both are 1 together only when WIDTH=1, which is not allowed.
- frame_done and the frame_count increment occur at the edge accepting the final beat.

Test Plan:
- WIDTH=8, HEIGHT=4, FRAME_GAP=2, LINE_GAP=0, tready=1, bg_mode=2, spot_en=0, enable held high -> 32 consecutive beats with tdata=0x000000,0x010101..0x070707 per line. tuser only on beat 0; tlast on beats 7,15,23,31; frame_done on beat 31; 2 idle cycles; next SOF; frame_count=1.
- Same config, spot_en=1, spot_x=6, spot_y=3, SPOT_SIZE=4, spot_color=0x00FF00 -> only beats (6,3) and (7,3) carry 0x00FF00; no spot pixels on lines 0-2 or at x<6 (clipping, no wrap).
- Random tready (~50% duty) for a full frame -> tdata/tuser/tlast unchanged during every stall; the accepted sequence is identical to the first scenario; exactly 32 accepts.
- LINE_GAP=3 -> after each accepted tlast, tvalid low exactly 3 cycles; after the final line, FRAME_GAP applies instead.
- enable dropped at beat 10; spot_x changed at beat 12 -> frame completes with the old spot; FSM goes to IDLE; busy=0 after the frame gap; no further tvalid.
- rst asserted mid-line with tvalid=1, tready=0 -> next cycle tvalid=0, frame_count=0. Re-enable gives tuser=1 with pixel (0,0).
